spi_seq_ctrl: RTL and testbench
===============================

Name: spi_seq_ctrl

Overview:
Transaction sequencer in front of the bit-level SPI shifter (spi_front).
- Accepts one command: target chip select, word count, narrow/wide mode.
- Drives chip-select timing and a per-word begin/busy handshake into the shifter.
- Streams TX words in and RX words out over valid/ready interfaces.
- Sits between the AXI-stream adaptation logic and spi_front, in the spi_clk_in domain.

Parameters:
NUM_CS, 4, number of active-low chip-select outputs (1..8)
LEN_W, 4, width of cmd_len; max burst = 2^LEN_W words
CS_SETUP, 2, cycles from cs_n assertion to first begin (1..15)
CS_HOLD, 2, cycles from last word complete to cs_n deassertion (1..15)
CS_GAP, 1, minimum cycles cs_n high before next command accepted (0..15)

Ports:
spi_clk_in  in  1  clock; all state updates on falling edge, aligned with spi_front
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  word count minus 1
cmd_wide  in  1  1 = 32-bit words, 0 = 8-bit words
cmd_cs  in  3  chip-select index; values >= NUM_CS are still accepted but no cs_n asserts
cmd_rx_en  in  1  1 = deliver RX words, 0 = discard
tx_data  in  32  next MOSI word
tx_valid  in  1  TX word available
tx_ready  out  1  TX word consumed this edge
rx_data  out  32  MISO word; narrow mode: bits 31:8 forced 0
rx_valid  out  1  RX word held
rx_ready  in  1  consumer accepts RX word
spi_cs_n  out  NUM_CS  chip selects, active low
front_begin  out  1  to spi_front spi_begin
front_wide  out  1  to spi_front spi_wide
front_data_mosi  out  32  to spi_front data_mosi
front_busy  in  1  from spi_front spi_busy
front_data_miso  in  32  from spi_front data_miso
seq_busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on GAP->IDLE / HOLD->IDLE

Behaviour:
- Reset, asynchronous: state IDLE; all counters 0; all spi_cs_n high; front_begin 0; front_data_mosi 0; rx_valid 0; rx_data 0; tx_ready 0; done 0; seq_busy 0.
- Reset mid-transfer: cs_n deasserts immediately; no RX word is delivered.
- Command latch: cmd_len, cmd_wide, cmd_cs and cmd_rx_en are latched at acceptance. front_wide is driven from the latched value and stays constant for the whole command.

States:
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch the command; assert spi_cs_n[cmd_cs] low; word counter = cmd_len; delay counter = CS_SETUP-1; go to SETUP.
- SETUP:
  - Count down the delay counter; at 0 go to LOAD.
- LOAD:
  - Wait until tx_valid=1 and (rx_valid=0, or rx_ready=1 on this edge, or cmd_rx_en=0).
  - Then pulse tx_ready for 1 cycle, register front_data_mosi=tx_data, set front_begin=1, go to START.
  - While waiting, begin stays 0 and cs_n stays asserted. TX underflow and RX backpressure both stall here with no timeout.
- START:
  - Hold front_begin=1 until front_busy=1 is sampled, then clear front_begin and go to XFER.
  - front_begin must fall before spi_front returns to idle; otherwise a spurious second transfer starts.
- XFER:
  - Wait for front_busy=0, then go to CAPTURE.
- CAPTURE (1 cycle):
  - If cmd_rx_en=1: rx_data = front_data_miso, or {24'b0, front_data_miso[7:0]} when narrow; set rx_valid=1.
  - If word counter = 0: delay counter = CS_HOLD-1, go to HOLD. Otherwise decrement the word counter and go to LOAD.
- HOLD:
  - Count down; at 0 deassert all cs_n.
  - If CS_GAP=0: go to IDLE with done=1. Otherwise load CS_GAP-1 and go to GAP.
- GAP:
  - Count down; at 0 go to IDLE and pulse done.

RX handshake:
- rx_valid clears on an edge where rx_ready=1 unless CAPTURE reloads it on that same edge; if both happen, rx_valid stays 1 with the new data.
- A pending RX word is never overwritten, because LOAD gates on the RX slot.

Latency and word count:
- Per-word minimum edges, LOAD to CAPTURE: narrow ~12, wide ~36.
- Word count = cmd_len+1; cmd_len=0 gives 1 word; an all-ones cmd_len gives 2^LEN_W words, with no wrap.

Other:
- Any illegal state encoding returns to IDLE with all cs_n high.

Test Plan:
- Single narrow word: cmd_cs=1, cmd_len=0, wide=0, rx_en=1; tx 0x000000A5; MISO model returns 0x3C → spi_cs_n=4'b1101 for the transfer; MOSI bits 1,0,1,0,0,1,0,1; rx_data=0x0000003C; exactly 1 rx_valid; done pulses once; cs_n high CS_HOLD cycles after busy falls.
- Wide burst: cmd_len=2, wide=1; tx 0x11223344, 0x55667788, 0x99AABBCC; loopback MISO → three rx words equal to the tx words, in order; cs_n low continuously across all words; 3 tx_ready pulses.
- TX underflow: tx_valid dropped for 20 cycles before word 2 → front_begin stays 0, cs_n stays low, and the transfer resumes correctly.
- RX backpressure: rx_ready=0 for 50 cycles after word 1 → no tx_ready or begin for word 2 until rx_ready=1; no RX data is lost.
- Discard and gap: rx_en=0, cmd_len=1, then a second command offered immediately → rx_valid never asserts; cmd_ready stays low for CS_HOLD+CS_GAP cycles after the last word.
- Reset mid-XFER: rst_n asserted low during a wide word → cs_n all 1, front_begin 0, rx_valid 0 immediately; the next command completes normally.

Source files
------------

// File: rtl/spi_seq_ctrl.sv
// spi_seq_ctrl: command sequencer driving chip-select timing and per-word begin/busy handshakes into spi_front
module spi_seq_ctrl #(
    parameter int NUM_CS   = 4,
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 1
) (
    input  logic              spi_clk_in,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_wide,
    input  logic [2:0]        cmd_cs,
    input  logic              cmd_rx_en,
    input  logic [31:0]       tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [31:0]       rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              front_begin,
    output logic              front_wide,
    output logic [31:0]       front_data_mosi,
    input  logic              front_busy,
    input  logic [31:0]       front_data_miso,
    output logic              seq_busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, START, XFER, CAPTURE, HOLD, GAP} state_t;
    state_t           state;
    logic [LEN_W-1:0] word_cnt;
    logic [3:0]       dly_cnt;
    logic             lat_rx_en;
    logic             rx_slot_free;
    assign cmd_ready    = state == IDLE;
    assign seq_busy     = state != IDLE;
    assign rx_slot_free = !rx_valid || rx_ready || !lat_rx_en;
    // Out-of-range cmd_cs shifts the one-hot bit out of the vector, leaving every select high.
    always_ff @(negedge spi_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            word_cnt        <= '0;
            dly_cnt         <= '0;
            lat_rx_en       <= 1'b0;
            spi_cs_n        <= '1;
            front_begin     <= 1'b0;
            front_wide      <= 1'b0;
            front_data_mosi <= '0;
            rx_data         <= '0;
            rx_valid        <= 1'b0;
            tx_ready        <= 1'b0;
            done            <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            done     <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    front_wide <= cmd_wide;
                    lat_rx_en  <= cmd_rx_en;
                    spi_cs_n   <= ~(NUM_CS'(1) << cmd_cs);
                    word_cnt   <= cmd_len;
                    dly_cnt    <= 4'(CS_SETUP - 1);
                    state      <= SETUP;
                end
                SETUP: if (dly_cnt == '0) state <= LOAD; else dly_cnt <= dly_cnt - 4'd1;
                LOAD: if (tx_valid && rx_slot_free) begin
                    tx_ready        <= 1'b1;
                    front_data_mosi <= tx_data;
                    front_begin     <= 1'b1;
                    state           <= START;
                end
                START: if (front_busy) begin
                    front_begin <= 1'b0;
                    state       <= XFER;
                end
                XFER: if (!front_busy) state <= CAPTURE;
                CAPTURE: begin
                    if (lat_rx_en) begin
                        rx_data  <= front_wide ? front_data_miso : {24'b0, front_data_miso[7:0]};
                        rx_valid <= 1'b1;
                    end
                    if (word_cnt == '0) begin
                        dly_cnt <= 4'(CS_HOLD - 1);
                        state   <= HOLD;
                    end else begin
                        word_cnt <= word_cnt - LEN_W'(1);
                        state    <= LOAD;
                    end
                end
                HOLD: if (dly_cnt != '0) dly_cnt <= dly_cnt - 4'd1;
                else begin
                    spi_cs_n <= '1;
                    if (CS_GAP == 0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        dly_cnt <= 4'(CS_GAP - 1);
                        state   <= GAP;
                    end
                end
                GAP: if (dly_cnt != '0) dly_cnt <= dly_cnt - 4'd1;
                else begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    spi_cs_n <= '1;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_seq_ctrl.sv
// tb_spi_seq_ctrl: scoreboard bench for spi_seq_ctrl with a behavioural spi_front model
module tb_spi_seq_ctrl;
    localparam int NUM_CS = 4, LEN_W = 4, CS_SETUP = 2, CS_HOLD = 2, CS_GAP = 1;
    localparam int BUDGET = 3000;
    logic              spi_clk_in = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid, cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_wide;
    logic [2:0]        cmd_cs;
    logic              cmd_rx_en;
    logic [31:0]       tx_data;
    logic              tx_valid, tx_ready;
    logic [31:0]       rx_data;
    logic              rx_valid, rx_ready;
    logic [NUM_CS-1:0] spi_cs_n;
    logic              front_begin, front_wide;
    logic [31:0]       front_data_mosi;
    logic              front_busy;
    logic [31:0]       front_data_miso;
    logic              seq_busy, done;
    int n_tests = 0, n_fail = 0;
    logic [31:0] tx_q[$];
    logic [32:0] exp_mosi[$];
    logic [31:0] exp_rx[$];
    logic        miso_ovr_en = 1'b0;
    logic [31:0] miso_ovr = '0;
    int n_done = 0, n_txr = 0, n_rx = 0, n_rxv = 0, n_beg = 0, n_rise = 0, n_xfer = 0, n_cslow = 0;
    logic [NUM_CS-1:0] cs_last = '1, prev_cs = '1;
    int          fcnt = 0;
    logic [31:0] cur_mosi = '0;
    logic [32:0] mon_e;

    spi_seq_ctrl #(.NUM_CS(NUM_CS), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
        .spi_clk_in(spi_clk_in), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_wide(cmd_wide),
        .cmd_cs(cmd_cs), .cmd_rx_en(cmd_rx_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .spi_cs_n(spi_cs_n), .front_begin(front_begin), .front_wide(front_wide),
        .front_data_mosi(front_data_mosi), .front_busy(front_busy), .front_data_miso(front_data_miso),
        .seq_busy(seq_busy), .done(done)
    );

    always #5 spi_clk_in = ~spi_clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
    endtask

    task automatic tick();
        @(posedge spi_clk_in);
        #1;
    endtask

    task automatic settle();
        @(negedge spi_clk_in);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic wide, input logic rxen);
        logic [31:0] m;
        m = miso_ovr_en ? miso_ovr : d;
        tx_q.push_back(d);
        exp_mosi.push_back({wide, d});
        if (rxen) exp_rx.push_back(wide ? m : {24'b0, m[7:0]});
    endtask

    task automatic send_cmd(input logic [2:0] cs, input logic [LEN_W-1:0] len, input logic wide, input logic rxen);
        int k;
        cmd_cs = cs; cmd_len = len; cmd_wide = wide; cmd_rx_en = rxen; cmd_valid = 1'b1;
        k = 0;
        do begin tick(); k++; end while (k < BUDGET && !cmd_ready);
        if (!cmd_ready) expire("cmd_accept");
        settle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        do begin tick(); k++; end while (k < BUDGET && !done);
        if (!done) expire(name);
        settle();
    endtask

    // spi_front model, RX/MOSI scoreboard monitor and activity counters, all on the rising edge
    initial begin
        front_busy = 1'b0;
        front_data_miso = '0;
        forever begin
            @(posedge spi_clk_in);
            if (done) n_done++;
            if (tx_ready) n_txr++;
            if (front_begin) n_beg++;
            if (rx_valid) n_rxv++;
            if (spi_cs_n != '1) begin cs_last = spi_cs_n; n_cslow++; end
            if (prev_cs != '1 && spi_cs_n == '1) n_rise++;
            prev_cs = spi_cs_n;
            if (rx_valid && rx_ready) begin
                n_rx++;
                if (exp_rx.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h, no word expected", rx_data);
                end else chk("rx_data", rx_data, exp_rx.pop_front());
            end
            if (!rst_n) begin
                front_busy = 1'b0; fcnt = 0; front_data_miso = '0;
            end else if (!front_busy) begin
                if (front_begin) begin
                    n_xfer++;
                    front_busy = 1'b1;
                    fcnt = front_wide ? 32 : 8;
                    cur_mosi = front_data_mosi;
                    if (exp_mosi.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL mosi_unexpected: got 0x%0h, no transfer expected", front_data_mosi);
                    end else begin
                        mon_e = exp_mosi.pop_front();
                        chk("front_wide", 32'(front_wide), 32'(mon_e[32]));
                        chk("front_mosi", front_data_mosi, mon_e[31:0]);
                    end
                end
            end else begin
                fcnt--;
                if (fcnt == 0) begin
                    front_busy = 1'b0;
                    front_data_miso = miso_ovr_en ? miso_ovr : cur_mosi;
                end
            end
        end
    end

    // TX source: presents the head of tx_q and retires it after each tx_ready pulse
    initial begin
        tx_valid = 1'b0;
        tx_data = '0;
        forever begin
            settle();
            if (tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
            tx_valid = tx_q.size() > 0;
            tx_data = tx_valid ? tx_q[0] : '0;
        end
    end

    initial begin
        int k, d0, t0, r0, b0, v0, x0, c0, hold, bad, post, lat, falls;
        logic prevb;
        cmd_valid = 1'b0; cmd_len = '0; cmd_wide = 1'b0; cmd_cs = '0; cmd_rx_en = 1'b0; rx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) settle();
        chk("rst_cs_n", 32'(spi_cs_n), 32'hF);
        chk("rst_begin", 32'(front_begin), 0);
        chk("rst_mosi", front_data_mosi, 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_seq_busy", 32'(seq_busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        settle();

        // single narrow word, MISO forced to 0x3C, RX held so the hold window is visible
        miso_ovr_en = 1'b1; miso_ovr = 32'h3C; rx_ready = 1'b0;
        push_word(32'hA5, 1'b0, 1'b1);
        d0 = n_done; t0 = n_txr; r0 = n_rx;
        send_cmd(3'd1, 4'd0, 1'b0, 1'b1);
        hold = 0; k = 0;
        do begin
            tick(); k++;
            if (rx_valid && spi_cs_n != '1) hold++;
        end while (k < BUDGET && !done);
        if (!done) expire("t1_done");
        chk("t1_cs_n", 32'(cs_last), 32'b1101);
        chk("t1_hold_cycles", hold, CS_HOLD);
        chk("t1_done_pulses", n_done - d0, 1);
        chk("t1_tx_ready_pulses", n_txr - t0, 1);
        chk("t1_rx_data_held", rx_data, 32'h3C);
        settle();
        rx_ready = 1'b1;
        repeat (3) settle();
        chk("t1_rx_words", n_rx - r0, 1);
        miso_ovr_en = 1'b0;

        // wide burst of three words on cs 0, loopback
        push_word(32'h11223344, 1'b1, 1'b1);
        push_word(32'h55667788, 1'b1, 1'b1);
        push_word(32'h99AABBCC, 1'b1, 1'b1);
        d0 = n_done; t0 = n_txr; r0 = n_rx; x0 = n_xfer; c0 = n_rise;
        send_cmd(3'd0, 4'd2, 1'b1, 1'b1);
        wait_done("t2_done");
        chk("t2_tx_ready_pulses", n_txr - t0, 3);
        chk("t2_rx_words", n_rx - r0, 3);
        chk("t2_xfers", n_xfer - x0, 3);
        chk("t2_cs_rises", n_rise - c0, 1);
        chk("t2_cs_n", 32'(cs_last), 32'b1110);
        chk("t2_done_pulses", n_done - d0, 1);

        // TX underflow before word 2
        push_word(32'h5A, 1'b0, 1'b1);
        t0 = n_txr; r0 = n_rx;
        send_cmd(3'd2, 4'd1, 1'b0, 1'b1);
        k = 0;
        do begin tick(); k++; end while (k < BUDGET && n_rx == r0);
        if (n_rx == r0) expire("t3_first_word");
        b0 = n_beg; bad = 0;
        repeat (20) begin
            tick();
            if (spi_cs_n != 4'b1011) bad++;
        end
        chk("t3_stall_begin", n_beg - b0, 0);
        chk("t3_stall_cs_n", bad, 0);
        chk("t3_stall_busy", 32'(seq_busy), 1);
        settle();
        push_word(32'hC3, 1'b0, 1'b1);
        wait_done("t3_done");
        chk("t3_rx_words", n_rx - r0, 2);
        chk("t3_tx_ready_pulses", n_txr - t0, 2);

        // RX backpressure for 50 cycles after word 1
        rx_ready = 1'b0;
        push_word(32'h81, 1'b0, 1'b1);
        push_word(32'h7E, 1'b0, 1'b1);
        t0 = n_txr; r0 = n_rx;
        send_cmd(3'd3, 4'd1, 1'b0, 1'b1);
        k = 0;
        do begin tick(); k++; end while (k < BUDGET && !rx_valid);
        if (!rx_valid) expire("t4_first_word");
        b0 = n_beg; d0 = n_txr;
        repeat (50) tick();
        chk("t4_stall_begin", n_beg - b0, 0);
        chk("t4_stall_tx_ready", n_txr - d0, 0);
        chk("t4_stall_rx_valid", 32'(rx_valid), 1);
        chk("t4_stall_rx_data", rx_data, 32'h81);
        settle();
        rx_ready = 1'b1;
        wait_done("t4_done");
        chk("t4_rx_words", n_rx - r0, 2);
        chk("t4_tx_ready_pulses", n_txr - t0, 2);
        chk("t4_cs_n", 32'(cs_last), 32'b0111);

        // discarded RX, then a second command offered immediately
        push_word(32'h11, 1'b0, 1'b0);
        push_word(32'h22, 1'b0, 1'b0);
        push_word(32'h33, 1'b0, 1'b1);
        v0 = n_rxv; d0 = n_done; r0 = n_rx;
        send_cmd(3'd0, 4'd1, 1'b0, 1'b0);
        cmd_cs = 3'd2; cmd_len = 4'd0; cmd_wide = 1'b0; cmd_rx_en = 1'b1; cmd_valid = 1'b1;
        falls = 0; post = 0; lat = 0; prevb = 1'b0; k = 0;
        // skip the busy-fall sample and the capture sample; the rest is hold plus gap
        do begin
            tick(); k++;
            if (prevb && !front_busy) falls++;
            prevb = front_busy;
            if (falls == 2) begin
                if (post >= 2 && !cmd_ready) lat++;
                post++;
            end
        end while (k < BUDGET && !(falls == 2 && cmd_ready));
        if (!cmd_ready) expire("t5_second_accept");
        chk("t5_ready_low_cycles", lat, CS_HOLD + CS_GAP);
        chk("t5_rx_valid_never", n_rxv - v0, 0);
        settle();
        cmd_valid = 1'b0;
        wait_done("t5_done");
        chk("t5_done_pulses", n_done - d0, 2);
        chk("t5_rx_words", n_rx - r0, 1);

        // reset in the middle of a wide word
        push_word(32'hDEADBEEF, 1'b1, 1'b1);
        r0 = n_rx;
        send_cmd(3'd1, 4'd0, 1'b1, 1'b1);
        k = 0;
        do begin tick(); k++; end while (k < BUDGET && !front_busy);
        if (!front_busy) expire("t6_busy");
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_cs_n", 32'(spi_cs_n), 32'hF);
        chk("t6_begin", 32'(front_begin), 0);
        chk("t6_rx_valid", 32'(rx_valid), 0);
        chk("t6_seq_busy", 32'(seq_busy), 0);
        tx_q.delete(); exp_mosi.delete(); exp_rx.delete();
        repeat (3) settle();
        rst_n = 1'b1;
        settle();
        chk("t6_no_rx", n_rx - r0, 0);
        push_word(32'h5A, 1'b0, 1'b1);
        d0 = n_done;
        send_cmd(3'd0, 4'd0, 1'b0, 1'b1);
        wait_done("t6_done");
        chk("t6_rx_words", n_rx - r0, 1);
        chk("t6_done_pulses", n_done - d0, 1);
        chk("t6_cs_n_after", 32'(cs_last), 32'b1110);

        // out-of-range chip select: command runs, no select asserts
        push_word(32'h96, 1'b0, 1'b1);
        c0 = n_cslow; r0 = n_rx;
        send_cmd(3'd5, 4'd0, 1'b0, 1'b1);
        wait_done("t7_done");
        chk("t7_cs_low_samples", n_cslow - c0, 0);
        chk("t7_rx_words", n_rx - r0, 1);

        // maximum burst: all-ones cmd_len gives 16 words
        for (int i = 0; i < 16; i++) push_word(32'(i * 7 + 1), 1'b0, 1'b1);
        t0 = n_txr; r0 = n_rx; x0 = n_xfer;
        send_cmd(3'd3, '1, 1'b0, 1'b1);
        wait_done("t8_done");
        chk("t8_tx_ready_pulses", n_txr - t0, 16);
        chk("t8_xfers", n_xfer - x0, 16);
        chk("t8_rx_words", n_rx - r0, 16);

        repeat (3) settle();
        chk("exp_rx_drained", exp_rx.size(), 0);
        chk("exp_mosi_drained", exp_mosi.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
